// File: rtl/team_06_echo_mem_ctrl.sv
// Echo delay-line controller: stores each audio sample in external SRAM and fetches a past one.
// Optional build macro TEAM06_ECHO_MEM_TIMEOUT_EN adds the mem_ack timeout and the timeout_err port.
module team_06_echo_mem_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [7:0]        audio_in,
    input  logic              search,
    input  logic [ADDR_W-1:0] offset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        past_output,
    output logic              past_valid,
    output logic              busy,
    output logic              overrun
`ifdef TEAM06_ECHO_MEM_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_t;

    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t            state, next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        sample_q;
    logic [7:0]        past_q;
    logic              search_q;
    logic              overrun_q;
    logic              read_req;
    logic              tmo_hit;
    logic              wr_skip;

    // A read only makes sense when the requested sample has actually been stored.
    assign read_req = search && (offset != '0) && (fill >= offset);

`ifdef TEAM06_ECHO_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_q;

    assign tmo_hit     = mem_req && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            wr_skip   <= 1'b0;
        end else begin
            if (mem_req && !mem_ack && !tmo_hit)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            else
                tmo_cnt <= '0;
            if (tmo_hit)
                timeout_q <= 1'b1;
            if (state == WR_REQ && tmo_hit)
                wr_skip <= 1'b1;
            else if (state == DONE)
                wr_skip <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign wr_skip = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: next_state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (sample_valid) next_state = read_req ? RD_REQ : WR_REQ;
            RD_REQ: if (mem_ack || tmo_hit) next_state = WR_REQ;
            WR_REQ: if (mem_ack || tmo_hit) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            rd_addr   <= '0;
            sample_q  <= '0;
            search_q  <= 1'b0;
            past_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (sample_valid && state != IDLE)
                overrun_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        sample_q <= audio_in;
                        search_q <= search;
                        rd_addr  <= wr_ptr - offset;
                        // Without a read the answer is known now: the sample itself, or silence.
                        if (search && !read_req)
                            past_q <= (offset == '0) ? audio_in : 8'h00;
                    end
                end
                RD_REQ: begin
                    if (mem_ack)
                        past_q <= mem_rdata;
                    else if (tmo_hit)
                        past_q <= 8'h00;
                end
                DONE: begin
                    if (!wr_skip) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (fill != FILL_MAX)
                            fill <= fill + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign mem_req     = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we      = (state == WR_REQ);
    assign mem_addr    = (state == RD_REQ) ? rd_addr : wr_ptr;
    assign mem_wdata   = sample_q;
    assign past_output = past_q;
    assign past_valid  = (state == DONE) && search_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_team_06_echo_mem_ctrl.sv
// Directed bench for team_06_echo_mem_ctrl with a behavioural SRAM responder.
// Build with TEAM06_ECHO_MEM_TIMEOUT_EN to also exercise the ack timeout.
module tb_team_06_echo_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [7:0]  audio_in;
    logic        search;
    logic [12:0] offset;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  past_output;
    logic        past_valid;
    logic        busy;
    logic        overrun;
`ifdef TEAM06_ECHO_MEM_TIMEOUT_EN
    logic        timeout_err;
`endif

    team_06_echo_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .search       (search),
        .offset       (offset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .past_output  (past_output),
        .past_valid   (past_valid),
        .busy         (busy),
        .overrun      (overrun)
`ifdef TEAM06_ECHO_MEM_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Responder state and transaction log.
    logic [7:0]  sram [0:8191];
    int          ack_delay = 1;
    int          wait_cnt  = 0;
    int          txn_seq   = 0;
    int          rd_cnt = 0, wr_cnt = 0, pv_cnt = 0;
    int          rd_seq = 0, wr_seq = 0;
    logic [12:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0, last_pv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // SRAM model: acks after ack_delay waiting cycles, acting on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int a = 0; a < 8192; a++) sram[a] = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (past_valid) begin
                pv_cnt++;
                last_pv = past_output;
            end
            if (mem_req && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    txn_seq++;
                    if (mem_we) begin
                        sram[mem_addr] = mem_wdata;
                        wr_cnt++;
                        wr_seq       = txn_seq;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end else begin
                        mem_rdata    = sram[mem_addr];
                        rd_cnt++;
                        rd_seq       = txn_seq;
                        last_rd_addr = mem_addr;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One sample period; lat = falling edges from strobe to past_valid (0 if none).
    // inj drives a second strobe one cycle later, while the controller is busy.
    task automatic send(input logic [7:0] a, input logic s, input logic [12:0] o,
                        input logic inj, output int lat);
        bit idle = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        audio_in     = a;
        search       = s;
        offset       = o;
        lat          = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1 && inj) begin
                sample_valid = 1'b1;
                audio_in     = 8'h99;
            end else begin
                sample_valid = 1'b0;
            end
            if (past_valid && lat == 0) lat = i;
            if (!busy && !sample_valid) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check("idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0, w0, p0;
        bit seen;

        rst = 1'b1;
        sample_valid = 1'b0;
        audio_in = '0;
        search = 1'b0;
        offset = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req",  {31'd0, mem_req},    32'd0);
        check("rst_mem_we",   {31'd0, mem_we},     32'd0);
        check("rst_mem_addr", {19'd0, mem_addr},   32'd0);
        check("rst_wdata",    {24'd0, mem_wdata},  32'd0);
        check("rst_past",     {24'd0, past_output},32'd0);
        check("rst_pvalid",   {31'd0, past_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_overrun",  {31'd0, overrun},    32'd0);
        rst = 1'b0;

        // Five plain writes, ack one cycle late.
        ack_delay = 1;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0, 13'd0, 1'b0, lat);
        check("fill_wr_cnt", wr_cnt, 5);
        check("fill_rd_cnt", rd_cnt, 0);
        check("fill_pv_cnt", pv_cnt, 0);
        check("fill_last_addr", {19'd0, last_wr_addr}, 32'd4);
        check("fill_sram0", {24'd0, sram[0]}, 32'h10);
        check("fill_sram4", {24'd0, sram[4]}, 32'h14);

        // offset 3 from wr_ptr 5 reads addr 2, then writes addr 5.
        send(8'h20, 1'b1, 13'd3, 1'b0, lat);
        check("echo_rd_addr", {19'd0, last_rd_addr}, 32'd2);
        check("echo_past",    {24'd0, last_pv}, 32'h12);
        check("echo_pv_cnt",  pv_cnt, 1);
        check("echo_wr_addr", {19'd0, last_wr_addr}, 32'd5);
        check("echo_sram5",   {24'd0, sram[5]}, 32'h20);
        check("echo_order",   {31'd0, rd_seq < wr_seq}, 32'd1);
        check("echo_lat",     lat, 5);

        // offset 0: echo of the sample itself, no read.
        r0 = rd_cnt;
        send(8'h33, 1'b1, 13'd0, 1'b0, lat);
        check("off0_past",  {24'd0, last_pv}, 32'h33);
        check("off0_no_rd", rd_cnt - r0, 0);

        // fill == offset (7): read allowed, addr 0.
        send(8'h34, 1'b1, 13'd7, 1'b0, lat);
        check("fill_eq_rd_addr", {19'd0, last_rd_addr}, 32'd0);
        check("fill_eq_past",    {24'd0, last_pv}, 32'h10);

        // fill (8) < offset (9): silence, no read.
        r0 = rd_cnt;
        p0 = pv_cnt;
        send(8'h35, 1'b1, 13'd9, 1'b0, lat);
        check("fill_lt_past",  {24'd0, last_pv}, 32'h00);
        check("fill_lt_no_rd", rd_cnt - r0, 0);
        check("fill_lt_pv",    pv_cnt - p0, 1);

        // Best-case latency with immediate acks.
        ack_delay = 0;
        send(8'h44, 1'b1, 13'd1, 1'b0, lat);
        check("lat0_cycles", lat, 3);
        check("lat0_past",   {24'd0, last_pv}, 32'h35);
        ack_delay = 1;
        send(8'h45, 1'b1, 13'd4, 1'b0, lat);
        check("lat1_cycles", lat, 5);
        check("lat1_past",   {24'd0, last_pv}, 32'h33);

        // Strobe during RD_REQ is dropped and flags overrun.
        ack_delay = 3;
        w0 = wr_cnt;
        send(8'h50, 1'b1, 13'd2, 1'b1, lat);
        check("ovr_flag",    {31'd0, overrun}, 32'd1);
        check("ovr_wr_cnt",  wr_cnt - w0, 1);
        check("ovr_wr_data", {24'd0, last_wr_data}, 32'h50);
        check("ovr_wr_addr", {19'd0, last_wr_addr}, 32'd11);
        check("ovr_past",    {24'd0, last_pv}, 32'h44);
        ack_delay = 1;
        send(8'h51, 1'b0, 13'd0, 1'b0, lat);
        check("ovr_sticky",  {31'd0, overrun}, 32'd1);

        // Reset in the middle of a write drops mem_req at once.
        ack_delay = 5;
        @(negedge clk);
        sample_valid = 1'b1;
        audio_in = 8'h66;
        search = 1'b0;
        offset = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (mem_req && mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_wr_seen", {31'd0, seen}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_req",     {31'd0, mem_req}, 32'd0);
        check("mid_rst_busy",    {31'd0, busy}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_addr",    {19'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fresh start: huge offset yields silence without a read; write lands at 0.
        ack_delay = 1;
        r0 = rd_cnt;
        p0 = pv_cnt;
        send(8'h55, 1'b1, 13'd8000, 1'b0, lat);
        check("big_off_no_rd", rd_cnt - r0, 0);
        check("big_off_pv",    pv_cnt - p0, 1);
        check("big_off_past",  {24'd0, last_pv}, 32'h00);
        check("big_off_waddr", {19'd0, last_wr_addr}, 32'd0);

        // Saturate fill and wrap wr_ptr to 2.
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 8194; i++) send(8'(i), 1'b0, 13'd0, 1'b0, lat);
        send(8'h77, 1'b1, 13'd5, 1'b0, lat);
        check("wrap_rd_addr", {19'd0, last_rd_addr}, 32'd8189);
        check("wrap_past",    {24'd0, last_pv}, 32'hfd);
        check("wrap_wr_addr", {19'd0, last_wr_addr}, 32'd2);
        send(8'h78, 1'b1, 13'd8191, 1'b0, lat);
        check("sat_rd_addr",  {19'd0, last_rd_addr}, 32'd4);
        check("sat_past",     {24'd0, last_pv}, 32'h04);

`ifdef TEAM06_ECHO_MEM_TIMEOUT_EN
        // No acks at all: read and write both time out, wr_ptr stays at 4.
        check("tmo_err_clear", {31'd0, timeout_err}, 32'd0);
        ack_delay = 1000;
        r0 = rd_cnt;
        send(8'h88, 1'b1, 13'd1, 1'b0, lat);
        check("tmo_lat",   lat, 31);
        check("tmo_err",   {31'd0, timeout_err}, 32'd1);
        check("tmo_past",  {24'd0, last_pv}, 32'h00);
        check("tmo_no_rd", rd_cnt - r0, 0);
        ack_delay = 0;
        send(8'h89, 1'b0, 13'd0, 1'b0, lat);
        check("tmo_wr_addr", {19'd0, last_wr_addr}, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
